// File: rtl/seq_divider.sv
// seq_divider: multicycle restoring integer divider (DIV / DIVU).
// One quotient bit is resolved per clock. The quotient and remainder are
// registered and hold their value until the next result is produced.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands are sampled on the accepting edge
// RUN   | WIDTH shift/subtract steps on the magnitudes
// FIX   | applies the sign fix or the divide-by-zero override, pulses done
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    // The partial remainder is always below the divisor after a step, so its
    // top bit is never set and only WIDTH bits of it are kept.
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] dividend_raw;
    logic             neg_q;
    logic             neg_r;
    logic             dz;

    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             fits;

    assign dividend_neg = is_signed & dividend[WIDTH-1];
    assign divisor_neg  = is_signed & divisor[WIDTH-1];

    // One restoring step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        trial = {r_reg, q_reg[WIDTH-1]};
        fits  = (trial >= {1'b0, d_reg});
        // When the subtraction is taken the true result is below 2^WIDTH,
        // so the truncated difference is exact.
        diff  = trial[WIDTH-1:0] - d_reg;
    end

    // Control FSM together with the datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            q_reg        <= '0;
            d_reg        <= '0;
            r_reg        <= '0;
            dividend_raw <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            dz           <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            div_by_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        neg_q        <= dividend_neg ^ divisor_neg;
                        neg_r        <= dividend_neg;
                        dz           <= (divisor == '0);
                        dividend_raw <= dividend;
                        // The negation of the most-negative value is its own
                        // pattern, which reads correctly as unsigned 2^(WIDTH-1).
                        q_reg        <= dividend_neg ? -dividend : dividend;
                        d_reg        <= divisor_neg ? -divisor : divisor;
                        r_reg        <= '0;
                        count        <= '0;
                        busy         <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    q_reg <= {q_reg[WIDTH-2:0], fits};
                    r_reg <= fits ? diff : trial[WIDTH-1:0];
                    count <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dz) begin
                        quotient  <= '1;
                        remainder <= dividend_raw;
                    end else begin
                        quotient  <= neg_q ? -q_reg : q_reg;
                        remainder <= neg_r ? -r_reg : r_reg;
                    end
                    div_by_zero <= dz;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider (WIDTH=32): directed and random divisions
// checked against an arithmetic reference model.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] prev_q = '0;
    logic [W-1:0] prev_r = '0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: MIPS DIV/DIVU semantics from plain integer arithmetic.
    task automatic model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        longint sa, sb, lq, lr;
        if (b == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[W-1:0];
            r  = lr[W-1:0];
            dz = 1'b0;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end
    endtask

    // Runs one division. preloaded: start/operands already driven in the
    // previous done cycle. poke_at: cycle at which a stray start is pulsed.
    // chain: drive the next start during this op's done cycle.
    task automatic run_op(input string tag, input bit s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit preloaded, input int poke_at,
                          input bit chain, input bit cs, input logic [W-1:0] ca,
                          input logic [W-1:0] cb);
        logic [W-1:0] eq, er;
        logic         edz;
        int           busy_cnt;
        bit           done_early;
        if (!preloaded) begin
            @(negedge clk);
            start     = 1'b1;
            is_signed = s;
            dividend  = a;
            divisor   = b;
        end
        model(s, a, b, eq, er, edz);
        @(posedge clk);
        #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom);
        check({tag, ".busy_after_accept"}, W'(busy), W'(1));
        check({tag, ".done_after_accept"}, W'(done), W'(0));
        busy_cnt   = 0;
        done_early = 1'b0;
        for (int k = 1; k <= W + 1; k++) begin
            if (k == poke_at) begin
                start     = 1'b1;
                is_signed = 1'b0;
                dividend  = 9;
                divisor   = 3;
            end
            @(posedge clk);
            #1;
            if (k == poke_at) start = 1'b0;
            if (k <= W) begin
                busy_cnt += int'(busy);
                if (done) done_early = 1'b1;
            end
            if (k == 16) begin
                check({tag, ".hold_q"}, quotient, prev_q);
                check({tag, ".hold_r"}, remainder, prev_r);
            end
        end
        check({tag, ".busy_cycles"}, W'(busy_cnt), W'(W));
        check({tag, ".done_early"}, W'(done_early), W'(0));
        check({tag, ".done"}, W'(done), W'(1));
        check({tag, ".busy_in_done"}, W'(busy), W'(0));
        check({tag, ".quotient"}, quotient, eq);
        check({tag, ".remainder"}, remainder, er);
        check({tag, ".dz"}, W'(div_by_zero), W'(edz));
        prev_q = eq;
        prev_r = er;
        if (chain) begin
            start     = 1'b1;
            is_signed = cs;
            dividend  = ca;
            divisor   = cb;
        end
    endtask

    initial begin
        bit           seen_done;
        bit           rs;
        logic [W-1:0] ra, rb;
        logic [W-1:0] dir_a [8] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFFF,
                                    32'h80000000, 32'h80000000, 32'd5, 32'hFFFFFFFB};
        logic [W-1:0] dir_b [8] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'd1,
                                    32'hFFFFFFFF, 32'd2, 32'd0, 32'd0};
        bit           dir_s [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", W'(busy), W'(0));
        check("rst.done", W'(done), W'(0));
        check("rst.q", quotient, '0);
        check("rst.r", remainder, '0);
        check("rst.dz", W'(div_by_zero), W'(0));
        reset = 1'b0;

        for (int i = 0; i < 8; i++)
            run_op($sformatf("dir%0d", i), dir_s[i], dir_a[i], dir_b[i], 1'b0, 0, 1'b0, 1'b0, '0, '0);

        // Stray start mid-run ignored; start in the done cycle chains.
        run_op("hs1", 1'b0, 32'd100, 32'd7, 1'b0, 10, 1'b1, 1'b0, 32'd9, 32'd3);
        run_op("hs2", 1'b0, 32'd9, 32'd3, 1'b1, 0, 1'b0, 1'b0, '0, '0);

        // Reset in the middle of a division.
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mrst.busy", W'(busy), W'(0));
        check("mrst.done", W'(done), W'(0));
        check("mrst.q", quotient, '0);
        check("mrst.r", remainder, '0);
        check("mrst.dz", W'(div_by_zero), W'(0));
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        check("mrst.no_done", W'(seen_done), W'(0));
        prev_q = '0;
        prev_r = '0;
        run_op("post_rst", 1'b0, 32'd20, 32'd6, 1'b0, 0, 1'b0, 1'b0, '0, '0);

        for (int i = 0; i < 16; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1, 2:    rb = W'($urandom_range(1, 15));
                3:       rb = -W'($urandom_range(1, 15));
                4:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if (i == 3) ra = 32'h80000000;
            run_op($sformatf("rnd%0d", i), rs, ra, rb, 1'b0, 0, 1'b0, 1'b0, '0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multicycle restoring integer divider for the MIPS execute stage. It implements DIV and DIVU, producing quotient (LO) and remainder (HI) one bit per clock. Start/busy/done handshake lets the pipeline stall, or keep issuing independent instructions, until HI/LO are valid. Sized at `WIDTH` bits, 32 in the CPU.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width; must be ≥ 2.

- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request a division; accepted only while idle (`busy`=0).
- `is_signed`  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with `start`.
- `dividend`  input  WIDTH  numerator; sampled on the accepting edge only.
- `divisor`  input  WIDTH  denominator; sampled on the accepting edge only.
- `busy`  output  1  high from the cycle after acceptance until the result cycle.
- `done`  output  1  one-cycle pulse; `quotient`/`remainder`/`div_by_zero` are valid in this cycle.
- `quotient`  output  WIDTH  registered quotient; holds until the next result.
- `remainder`  output  WIDTH  registered remainder; holds until the next result.
- `div_by_zero`  output  1  registered; set with `done` when the divisor was 0.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, `start`=1:
  - Latch `neg_q` (signs differ) and `neg_r` (dividend sign), both forced 0 when `is_signed`=0.
  - Latch `dz` = (divisor==0).
  - Load Q = |dividend|, D = |divisor| (raw values when unsigned), and R = 0, R being WIDTH+1 bits.
  - Load count = 0, then go to RUN.
- IDLE, `start`=0: stay in IDLE.
- RUN, each cycle:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]}; Q shifts left by 1.
  - If T ≥ {0,D}: R = T − D and Q[0] = 1; else R = T and Q[0] = 0.
  - count increments; after the WIDTH-th step, go to FIX.
- FIX (one cycle):
  - quotient ← neg_q ? −Q : Q; remainder ← neg_r ? −R[WIDTH-1:0] : R[WIDTH-1:0].
  - div_by_zero ← dz; done ← 1; go to IDLE.
- Divide by zero: no special path; the algorithm runs normally.
  - The override applies whenever `dz` is set: quotient = all ones, remainder = original dividend bit pattern, no sign fix.
  - Full latency still applies.
- Signed semantics: truncate toward zero; the remainder takes the dividend's sign.
- Signed overflow: most-negative ÷ −1 gives quotient = 2^(WIDTH-1) bit pattern (wraps) and remainder 0. No flag.
- Absolute value of the most-negative number is its own bit pattern, treated as unsigned 2^(WIDTH-1); the path must be WIDTH-bit unsigned-correct.
- `start` while `busy`=1 is ignored; there is no queueing and the operation in flight is unaffected.
- Operand inputs may change freely after the accepting edge.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, count=0.
- Reset mid-operation: abort immediately, return to IDLE with reset values, no `done` pulse.
- Reset has priority over `start` in the same cycle.
- Latency: if the edge accepting `start` is E0, RUN steps occur at E1..E_WIDTH and FIX at E_(WIDTH+1).
  - `done`=1 during the cycle after E_(WIDTH+1), i.e. WIDTH+1 cycles after acceptance (33 for WIDTH=32).
- `busy`=1 in the cycles following E0 through E_WIDTH (RUN and FIX); `busy`=0 in the `done` cycle.
- Back-to-back: `start` during the `done` cycle is accepted (state is IDLE); its `done` follows WIDTH+1 cycles later.
- `done` is never high for two consecutive cycles.
- Outputs change only at FIX or reset; they are stable between results.
- Throughput: one division per WIDTH+1 cycles.

## Test plan
- DIVU 100 ÷ 7 -> quotient=14, remainder=2, div_by_zero=0; `done` exactly 33 cycles after acceptance and for one cycle; `busy` high 32 cycles.
- DIV −7 ÷ 2 (0xFFFFFFF9, 0x2) -> quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1). DIV 7 ÷ −2 -> quotient=0xFFFFFFFD, remainder=1.
- Boundary values:
  - DIVU 0xFFFFFFFF ÷ 1 -> quotient=0xFFFFFFFF, remainder=0.
  - DIV 0x80000000 ÷ 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
  - DIV 0x80000000 ÷ 2 -> quotient=0xC0000000, remainder=0.
- Divide by zero, both modes: DIVU 5 ÷ 0 and DIV −5 ÷ 0 -> quotient=0xFFFFFFFF, remainder=dividend pattern, div_by_zero=1, same 33-cycle latency.
- Handshake sequence:
  - Start 100 ÷ 7.
  - Pulse `start` with 9 ÷ 3 at cycle 10 -> ignored, result is 14 r 2.
  - Assert `start` with 9 ÷ 3 in the `done` cycle -> second `done` 33 cycles later with quotient=3, remainder=0.
- Reset at cycle 10 of a division -> next cycle `busy`=0, outputs 0, no `done` pulse ever appears. A fresh 20 ÷ 6 afterwards -> quotient=3, remainder=2.
